// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and config check for seq_detector_prog
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_FILL  = 2'd1,
        S_HUNT  = 2'd2
    } seq_det_state_t;

    localparam int SEQ_DET_MAX_LEN_DEF = 8;
    localparam int SEQ_DET_CNT_W_DEF   = 16;

    function automatic logic len_ok(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating event counter with synchronous clear
module seq_det_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - programmable serial pattern detector; SEQ_DET_MATCH_CNT_EN adds match_cnt
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = SEQ_DET_MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = SEQ_DET_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    output logic               z,
    output logic               armed,
    output logic               cfg_err
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    seq_det_state_t     state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               z_d, err_d;

    logic               cfg_ok;
    logic               beat;
    logic               match;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;

    // Only the newest len_q bits of history take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        pat_d    = pat_q;
        fill_d   = fill_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        z_d      = 1'b0;
        cfg_ok   = len_ok(int'(cfg_len), MAX_LEN);
        err_d    = cfg_load && !cfg_ok;
        beat     = en && in_valid && (state_q != S_UNCFG) && !cfg_load;
        shifted  = {hist_q[MAX_LEN-2:0], x};
        fill_inc = {1'b0, fill_q} + 1'b1;
        match    = beat && (fill_inc >= {1'b0, len_q}) && (((shifted ^ pat_q) & mask) == '0);

        if (cfg_load) begin
            if (cfg_ok) begin
                len_d   = cfg_len;
                pat_d   = cfg_pattern;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = S_FILL;
            end
        end else if (beat) begin
            hist_d = shifted;
            z_d    = match;
            // Non-overlapping mode restarts the fill count; history bits stay but are masked out by fill.
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = S_FILL;
            end else if (fill_inc >= {1'b0, len_q}) begin
                fill_d  = len_q;
                state_d = S_HUNT;
            end else begin
                fill_d  = fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNCFG;
            hist_q  <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b1;
            z       <= 1'b0;
            armed   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            z       <= z_d;
            armed   <= (state_d == S_HUNT);
            cfg_err <= err_d;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load && cfg_ok),
        .inc (z_d),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - randomized and directed self-checking bench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               cfg_load = 1'b0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               x = 1'b0;
    logic               z, armed, cfg_err;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: config plus the list of bits collected since the last clear.
    bit                 m_cfg;
    int                 m_len;
    logic [MAX_LEN-1:0] m_pat;
    bit                 m_ovl;
    bit                 m_q[$];
    logic               exp_z, exp_armed, exp_err;
    logic [CNT_W-1:0]   exp_cnt;

    always #5 clk = ~clk;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_len     (cfg_len),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .x           (x),
        .z           (z),
        .armed       (armed),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    task automatic model_step(input logic r, e, ld, input int l, input logic [MAX_LEN-1:0] p,
                              input logic o, v, b);
        bit hit;
        exp_z   = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            m_cfg = 0; m_len = 0; m_pat = '0; m_ovl = 1; m_q.delete(); exp_cnt = '0;
        end else if (ld) begin
            if (l >= 1 && l <= MAX_LEN) begin
                m_cfg = 1; m_len = l; m_pat = p; m_ovl = o; m_q.delete(); exp_cnt = '0;
            end else begin
                exp_err = 1'b1;
            end
        end else if (e && v && m_cfg) begin
            m_q.push_back(b);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            hit = (m_q.size() >= m_len);
            for (int k = 0; k < m_len && hit; k++) begin
                if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 0;
            end
            if (hit) begin
                exp_z = 1'b1;
                if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                if (!m_ovl) m_q.delete();
            end
        end
        exp_armed = m_cfg && (m_q.size() >= m_len);
    endtask

    task automatic cyc(input logic r, e, ld, input int l, input logic [MAX_LEN-1:0] p,
                       input logic o, v, b);
        logic [31:0] lw;
        lw = l;
        rst = r; en = e; cfg_load = ld; cfg_len = lw[LEN_W-1:0];
        cfg_pattern = p; cfg_overlap = o; in_valid = v; x = b;
        @(posedge clk);
        model_step(r, e, ld, l, p, o, v, b);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, '0, 0, 0, 0);
        cyc(1, 0, 0, 0, '0, 0, 0, 0);
        n_tests++;
        if (z !== 1'b0 || armed !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: z/armed/err=%b%b%b expected 000", z, armed, cfg_err);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed || z !== 1'b0 || armed !== 1'b0) begin
                n_fail++;
                $display("FAIL unconfigured beat %0d: z/armed=%b%b expected 00", i, z, armed);
            end
        end
    endtask

    task automatic test_overlap();
        logic [9:0] s;
        int pulses;
        s = 10'b1010101010;
        pulses = 0;
        cyc(0, 1, 1, 6, 8'b0010_1010, 1, 0, 0);
        for (int i = 9; i >= 0; i--) begin
            cyc(0, 1, 0, 0, '0, 0, 1, s[i]);
            pulses += int'(z);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed) begin
                n_fail++;
                $display("FAIL overlap beat %0d: z/armed=%b%b expected %b%b", 10 - i, z, armed, exp_z, exp_armed);
            end
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL overlap count: %0d pulses expected 3", pulses);
        end
    endtask

    task automatic test_nonoverlap();
        logic [11:0] s;
        int pulses;
        s = 12'b1010_1010_1010;
        pulses = 0;
        cyc(0, 1, 1, 6, 8'b0010_1010, 0, 0, 0);
        for (int i = 11; i >= 0; i--) begin
            cyc(0, 1, 0, 0, '0, 0, 1, s[i]);
            pulses += int'(z);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed) begin
                n_fail++;
                $display("FAIL nonoverlap beat %0d: z/armed=%b%b expected %b%b", 12 - i, z, armed, exp_z, exp_armed);
            end
        end
        n_tests++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL nonoverlap count: %0d pulses expected 2", pulses);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        n_tests++;
        if (match_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL nonoverlap match_cnt: %0d expected 2", match_cnt);
        end
`endif
    endtask

    task automatic test_gaps();
        logic [9:0] ve, vv, vb;
        int pulses;
        // Columns left to right: 1 0 1, three idle cycles, one en-gated 1, then 0 1 0.
        ve = 10'b1111110111;
        vv = 10'b1110001111;
        vb = 10'b1010101010;
        pulses = 0;
        cyc(0, 1, 1, 6, 8'b0010_1010, 1, 0, 0);
        for (int i = 9; i >= 0; i--) begin
            cyc(0, ve[i], 0, 0, '0, 0, vv[i], vb[i]);
            pulses += int'(z);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed) begin
                n_fail++;
                $display("FAIL gaps cycle %0d: z/armed=%b%b expected %b%b", 10 - i, z, armed, exp_z, exp_armed);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL gaps count: %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_bad_cfg();
        logic armed_before;
        int bad_len[2];
        bad_len[0] = 0;
        bad_len[1] = MAX_LEN + 1;
        for (int j = 0; j < 2; j++) begin
            armed_before = armed;
            cyc(0, 1, 1, bad_len[j], 8'hFF, 1, 1, 1'b1);
            n_tests++;
            if (cfg_err !== 1'b1 || cfg_err !== exp_err || armed !== armed_before) begin
                n_fail++;
                $display("FAIL bad_cfg len %0d: err/armed=%b%b expected 1%b", bad_len[j], cfg_err, armed, armed_before);
            end
            cyc(0, 1, 0, 0, '0, 0, 0, 0);
            n_tests++;
            if (cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_cfg pulse len %0d: err=%b expected 0", bad_len[j], cfg_err);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0, '0, 0, 1, (i % 2 == 0) ? 1'b1 : 1'b0);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed) begin
                n_fail++;
                $display("FAIL bad_cfg retained beat %0d: z/armed=%b%b expected %b%b", i, z, armed, exp_z, exp_armed);
            end
        end
    endtask

    task automatic test_reload();
        int pulses;
        logic [4:0] pre;
        pre = 5'b10101;
        pulses = 0;
        cyc(0, 1, 1, 6, 8'b0010_1010, 1, 0, 0);
        for (int i = 4; i >= 0; i--) cyc(0, 1, 0, 0, '0, 0, 1, pre[i]);
        cyc(0, 1, 1, 3, 8'b0000_0111, 1, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
            pulses += int'(z);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed || z !== (i == 2)) begin
                n_fail++;
                $display("FAIL reload beat %0d: z/armed=%b%b expected %b%b", i + 1, z, armed, exp_z, exp_armed);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL reload count: %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_collision();
        cyc(0, 1, 1, 3, 8'b0000_0111, 1, 0, 0);
        cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
        cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
        cyc(0, 1, 1, 3, 8'b0000_0111, 1, 1, 1'b1);
        n_tests++;
        if (z !== 1'b0 || z !== exp_z || armed !== exp_armed) begin
            n_fail++;
            $display("FAIL collision: z/armed=%b%b expected 0%b", z, armed, exp_armed);
        end
    endtask

    task automatic test_rst_mid();
        cyc(0, 1, 1, 2, 8'b0000_0011, 1, 0, 0);
        cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
        cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
        cyc(1, 1, 0, 0, '0, 0, 1, 1'b1);
        n_tests++;
        if (z !== 1'b0 || armed !== 1'b0 || exp_armed !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: z/armed=%b%b expected 00", z, armed);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, '0, 0, 1, 1'b1);
            n_tests++;
            if (z !== 1'b0 || armed !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid ignored beat %0d: z/armed=%b%b expected 00", i, z, armed);
            end
        end
    endtask

    task automatic test_random();
        logic r, e, ld, o, v, b;
        int l;
        logic [MAX_LEN-1:0] p;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MAX_LEN + 1) : $urandom_range(1, 4);
            p  = MAX_LEN'($urandom);
            o  = 1'($urandom);
            e  = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 2) != 0);
            cyc(r, e, ld, l, p, o, v, b);
            n_tests++;
            if (z !== exp_z || armed !== exp_armed || cfg_err !== exp_err) begin
                n_fail++;
                $display("FAIL random cycle %0d: z/armed/err=%b%b%b expected %b%b%b",
                         i, z, armed, cfg_err, exp_z, exp_armed, exp_err);
            end
`ifdef SEQ_DET_MATCH_CNT_EN
            n_tests++;
            if (match_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL random match_cnt cycle %0d: %0d expected %0d", i, match_cnt, exp_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_bad_cfg();
        test_reload();
        test_collision();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
